// File: rtl/muldiv_seq.sv
// muldiv_seq: sequences one M-extension op between execute and muldiv, picks the result slice for writeback.
// Latency: mul-class 3 cycles, div-class 3 + divider run, non-M or fused pair hit 1 cycle (pair cache under MULDIV_PAIR_FUSE_EN).
// Backpressure: req_ready_o only while idle; result held stable on res_* until res_ready_i.
`timescale 1ns/1ps

package RS5_pkg;
    // Subset of the core's instruction-type enum that this block cares about; ADD stands for any non-M op.
    typedef enum logic [3:0] {
        NOP, ADD, MUL, MULH, MULHU, MULHSU, DIV, DIVU, REM, REMU
    } iType_e;
endpackage

module muldiv_seq
    import RS5_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  iType_e      req_op_i,
    input  logic [31:0] req_rs1_i,
    input  logic [31:0] req_rs2_i,
    input  logic [4:0]  req_rd_i,
    input  logic        flush_i,
    output iType_e      md_op_o,
    output logic [31:0] md_opa_o,
    output logic [31:0] md_opb_o,
    input  logic        md_hold_i,
    input  logic [63:0] md_mul_i,
    input  logic [63:0] md_mulh_i,
    input  logic [63:0] md_mulhsu_i,
    input  logic [31:0] md_div_i,
    input  logic [31:0] md_divu_i,
    input  logic [31:0] md_rem_i,
    input  logic [31:0] md_remu_i,
    output logic        res_valid_o,
    input  logic        res_ready_i,
    output logic [31:0] res_data_o,
    output logic [4:0]  res_rd_o
);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_e;

    state_e      state, state_nxt;
    iType_e      op_q;
    logic [31:0] rs1_q, rs2_q, res_data_q;
    logic [4:0]  rd_q;
    logic        flush_pend;
    logic        accept, wait_done, capture, req_is_m;
    logic        fuse_hit;
    logic [31:0] fuse_val;
    logic [31:0] slice;

    function automatic logic is_mul_class(input iType_e op);
        return (op == MUL) || (op == MULH) || (op == MULHU) || (op == MULHSU);
    endfunction

    function automatic logic is_div_class(input iType_e op);
        return (op == DIV) || (op == DIVU) || (op == REM) || (op == REMU);
    endfunction

    // Flush beats a same-cycle request; the request is dropped, not queued.
    assign accept    = (state == S_IDLE) && req_valid_i && !flush_i;
    assign req_is_m  = is_mul_class(req_op_i) || is_div_class(req_op_i);
    // muldiv finished its run (hold low after the start cycle).
    assign wait_done = (state == S_WAIT) && !md_hold_i;
    // A flushed op still runs to completion in muldiv but its result is dropped.
    assign capture   = wait_done && !flush_pend && !flush_i;

`ifdef MULDIV_PAIR_FUSE_EN
    logic        fuse_vld, fuse_signed, fuse_rem;
    logic [31:0] fuse_rs1, fuse_rs2, fuse_quo, fuse_rmd;
    logic        req_signed, req_rem;

    assign req_signed = (req_op_i == DIV) || (req_op_i == REM);
    assign req_rem    = (req_op_i == REM) || (req_op_i == REMU);
    // Only the partner of the op that filled the cache hits; a repeat of the same op re-runs muldiv.
    assign fuse_hit   = fuse_vld && is_div_class(req_op_i) && (req_signed == fuse_signed) &&
                        (req_rem != fuse_rem) && (req_rs1_i == fuse_rs1) && (req_rs2_i == fuse_rs2);
    assign fuse_val   = fuse_rem ? fuse_quo : fuse_rmd;

    // Pair cache: keep quotient and remainder of the last completed divide.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fuse_vld    <= 1'b0;
            fuse_signed <= 1'b0;
            fuse_rem    <= 1'b0;
            fuse_rs1    <= '0;
            fuse_rs2    <= '0;
            fuse_quo    <= '0;
            fuse_rmd    <= '0;
        end else if (flush_i) begin
            fuse_vld <= 1'b0;
        end else if (accept && is_mul_class(req_op_i)) begin
            fuse_vld <= 1'b0;
        end else if (capture && is_div_class(op_q)) begin
            fuse_vld    <= 1'b1;
            fuse_signed <= (op_q == DIV) || (op_q == REM);
            fuse_rem    <= (op_q == REM) || (op_q == REMU);
            fuse_rs1    <= rs1_q;
            fuse_rs2    <= rs2_q;
            fuse_quo    <= ((op_q == DIV) || (op_q == REM)) ? md_div_i : md_divu_i;
            fuse_rmd    <= ((op_q == DIV) || (op_q == REM)) ? md_rem_i : md_remu_i;
        end
    end
`else
    assign fuse_hit = 1'b0;
    assign fuse_val = '0;
`endif

    // Low product halves of the high-multiply buses are not needed here.
    logic unused_low;
    assign unused_low = ^{md_mulh_i[31:0], md_mulhsu_i[31:0]};

    // Result slice for the latched op.
    always_comb begin
        slice = '0;
        case (op_q)
            MUL:     slice = md_mul_i[31:0];
            MULHU:   slice = md_mul_i[63:32];
            MULH:    slice = md_mulh_i[63:32];
            MULHSU:  slice = md_mulhsu_i[63:32];
            DIV:     slice = md_div_i;
            DIVU:    slice = md_divu_i;
            REM:     slice = md_rem_i;
            REMU:    slice = md_remu_i;
            default: slice = '0;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nxt;
    end

    // Next state.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (accept) state_nxt = (!req_is_m || fuse_hit) ? S_DONE : S_ISSUE;
            S_ISSUE: state_nxt = S_WAIT;
            S_WAIT:  if (!md_hold_i) state_nxt = (flush_pend || flush_i) ? S_IDLE : S_DONE;
            S_DONE:  if (flush_i || res_ready_i) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Outputs decoded from state; muldiv sees NOP outside ISSUE/WAIT so its flags clear between ops.
    always_comb begin
        req_ready_o = 1'b0;
        md_op_o     = NOP;
        res_valid_o = 1'b0;
        case (state)
            S_IDLE:         req_ready_o = 1'b1;
            S_ISSUE,
            S_WAIT:         md_op_o     = op_q;
            S_DONE:         res_valid_o = 1'b1;
            default:        req_ready_o = 1'b0;
        endcase
    end

    assign md_opa_o   = rs1_q;
    assign md_opb_o   = rs2_q;
    assign res_data_o = res_data_q;
    assign res_rd_o   = rd_q;

    // Request latch and result capture; operands only move on accept, so they are frozen while muldiv runs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            op_q       <= NOP;
            rs1_q      <= '0;
            rs2_q      <= '0;
            rd_q       <= '0;
            res_data_q <= '0;
        end else if (accept) begin
            op_q       <= req_op_i;
            rs1_q      <= req_rs1_i;
            rs2_q      <= req_rs2_i;
            rd_q       <= req_rd_i;
            res_data_q <= fuse_hit ? fuse_val : '0;
        end else if (capture) begin
            res_data_q <= slice;
        end
    end

    // Remember a flush that arrives while muldiv is busy; cleared when muldiv releases hold.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)                                                    flush_pend <= 1'b0;
        else if (wait_done)                                           flush_pend <= 1'b0;
        else if (((state == S_ISSUE) || (state == S_WAIT)) && flush_i) flush_pend <= 1'b1;
    end

endmodule

// File: tb/tb_muldiv_seq.sv
// tb_muldiv_seq: drives muldiv_seq against a behavioural muldiv stub and an arithmetic reference model.
// Latency: n/a.
// Backpressure: stalls res_ready_i for random cycles per op.
`timescale 1ns/1ps

module tb_muldiv_seq;
    import RS5_pkg::*;

`ifdef MULDIV_PAIR_FUSE_EN
    localparam bit FUSE = 1'b1;
`else
    localparam bit FUSE = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid_i, req_ready_o, flush_i, md_hold_i, res_valid_o, res_ready_i;
    iType_e      req_op_i, md_op_o;
    logic [31:0] req_rs1_i, req_rs2_i, md_opa_o, md_opb_o, res_data_o;
    logic [31:0] md_div_i, md_divu_i, md_rem_i, md_remu_i;
    logic [63:0] md_mul_i, md_mulh_i, md_mulhsu_i;
    logic [4:0]  req_rd_i, res_rd_o;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    muldiv_seq dut (
        .clk(clk), .reset(reset),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_op_i(req_op_i),
        .req_rs1_i(req_rs1_i), .req_rs2_i(req_rs2_i), .req_rd_i(req_rd_i), .flush_i(flush_i),
        .md_op_o(md_op_o), .md_opa_o(md_opa_o), .md_opb_o(md_opb_o), .md_hold_i(md_hold_i),
        .md_mul_i(md_mul_i), .md_mulh_i(md_mulh_i), .md_mulhsu_i(md_mulhsu_i),
        .md_div_i(md_div_i), .md_divu_i(md_divu_i), .md_rem_i(md_rem_i), .md_remu_i(md_remu_i),
        .res_valid_o(res_valid_o), .res_ready_i(res_ready_i), .res_data_o(res_data_o), .res_rd_o(res_rd_o)
    );

    // RISC-V M-extension result computed with wide integer arithmetic.
    function automatic logic [31:0] rv(input iType_e op, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, ua, ub;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'(a);
        ub = longint'(b);
        case (op)
            MUL:     begin p = sa * sb; return p[31:0];  end
            MULH:    begin p = sa * sb; return p[63:32]; end
            MULHU:   begin p = ua * ub; return p[63:32]; end
            MULHSU:  begin p = sa * ub; return p[63:32]; end
            DIV:     return (b == 0) ? 32'hFFFF_FFFF : 32'(sa / sb);
            DIVU:    return (b == 0) ? 32'hFFFF_FFFF : 32'(ua / ub);
            REM:     return (b == 0) ? a : 32'(sa % sb);
            REMU:    return (b == 0) ? a : 32'(ua % ub);
            default: return 32'h0;
        endcase
    endfunction

    function automatic bit is_mulc(input iType_e op);
        return (op == MUL) || (op == MULH) || (op == MULHU) || (op == MULHSU);
    endfunction
    function automatic bit is_divc(input iType_e op);
        return (op == DIV) || (op == DIVU) || (op == REM) || (op == REMU);
    endfunction
    function automatic bit is_sgn(input iType_e op);
        return (op == DIV) || (op == REM);
    endfunction
    function automatic bit is_rem(input iType_e op);
        return (op == REM) || (op == REMU);
    endfunction
    function automatic iType_e partner(input iType_e op);
        case (op)
            DIV:     return REM;
            REM:     return DIV;
            DIVU:    return REMU;
            default: return DIVU;
        endcase
    endfunction

    // muldiv stub: holds on the start cycle, divides hold div_extra more cycles (none on divide-by-zero);
    // outputs are garbage (inverted) while hold is high.
    int div_extra = 0;
    int md_cnt;
    int md_lat;
    always @(posedge clk or posedge reset) begin
        if (reset)               md_cnt <= 0;
        else if (md_op_o == NOP) md_cnt <= 0;
        else                     md_cnt <= md_cnt + 1;
    end
    always_comb begin
        md_lat = 1;
        if (is_divc(md_op_o) && md_opb_o != 32'd0) md_lat = 1 + div_extra;
        md_hold_i   = (md_op_o != NOP) && (md_cnt < md_lat);
        md_mul_i    = {rv(MULHU, md_opa_o, md_opb_o), rv(MUL, md_opa_o, md_opb_o)};
        md_mulh_i   = {rv(MULH, md_opa_o, md_opb_o), rv(MUL, md_opa_o, md_opb_o)};
        md_mulhsu_i = {rv(MULHSU, md_opa_o, md_opb_o), rv(MUL, md_opa_o, md_opb_o)};
        md_div_i    = rv(DIV, md_opa_o, md_opb_o);
        md_divu_i   = rv(DIVU, md_opa_o, md_opb_o);
        md_rem_i    = rv(REM, md_opa_o, md_opb_o);
        md_remu_i   = rv(REMU, md_opa_o, md_opb_o);
        if (md_hold_i) begin
            md_mul_i    = ~md_mul_i;
            md_mulh_i   = ~md_mulh_i;
            md_mulhsu_i = ~md_mulhsu_i;
            md_div_i    = ~md_div_i;
            md_divu_i   = ~md_divu_i;
            md_rem_i    = ~md_rem_i;
            md_remu_i   = ~md_remu_i;
        end
    end

    // Reference pair-cache state.
    bit          fv = 1'b0;
    bit          fsg, frem;
    logic [31:0] fa, fb;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // One full request/response; all tasks start and end just after a negedge.
    task automatic do_op(input iType_e op, input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd,
                         input int dext, input int stall, output logic [31:0] got);
        bit          hit, md_idle, md_bad, unstable;
        int          exp_lat, lat;
        logic [31:0] exp;
        hit     = FUSE && fv && is_divc(op) && (is_sgn(op) == fsg) && (is_rem(op) != frem) && a == fa && b == fb;
        md_idle = !(is_mulc(op) || is_divc(op)) || hit;
        exp_lat = md_idle ? 1 : (is_divc(op) && b != 0) ? 3 + dext : 3;
        exp     = rv(op, a, b);
        if (is_mulc(op)) fv = 1'b0;
        else if (is_divc(op) && !hit && FUSE) begin
            fv = 1'b1; fsg = is_sgn(op); frem = is_rem(op); fa = a; fb = b;
        end
        div_extra = dext;
        chk("req_ready_idle", req_ready_o, 1);
        req_valid_i = 1'b1; req_op_i = op; req_rs1_i = a; req_rs2_i = b; req_rd_i = rd;
        @(negedge clk);
        req_valid_i = 1'b0; req_op_i = NOP; req_rs1_i = $urandom; req_rs2_i = $urandom; req_rd_i = 5'($urandom);
        lat = 1; md_bad = 1'b0;
        while (!res_valid_o && lat < 100) begin
            if (md_idle) md_bad |= (md_op_o != NOP);
            else if (md_op_o != op || md_opa_o != a || md_opb_o != b) md_bad = 1'b1;
            @(negedge clk);
            lat++;
        end
        chk("latency", lat, exp_lat);
        chk("md_drive", md_bad, 0);
        chk("res_data", res_data_o, exp);
        chk("res_rd", res_rd_o, rd);
        got = res_data_o;
        unstable = 1'b0;
        for (int i = 0; i <= stall; i++) begin
            if (!res_valid_o || res_data_o != exp || res_rd_o != rd || req_ready_o || md_op_o != NOP) unstable = 1'b1;
            if (i < stall) @(negedge clk);
        end
        chk("done_stable", unstable, 0);
        res_ready_i = 1'b1;
        @(negedge clk);
        res_ready_i = 1'b0;
        chk("drained", {res_valid_o, req_ready_o}, 2'b01);
    endtask

    // Flush a DIVU while muldiv is busy; the op must keep driving until hold drops, then return idle silently.
    task automatic flush_busy(input logic [31:0] a, input logic [31:0] b, input int dext, input int flush_at);
        int cyc;
        bit md_bad, seen_valid;
        div_extra = dext;
        fv = 1'b0;
        req_valid_i = 1'b1; req_op_i = DIVU; req_rs1_i = a; req_rs2_i = b; req_rd_i = 5'd9;
        @(negedge clk);
        req_valid_i = 1'b0; req_op_i = NOP;
        cyc = 1; md_bad = 1'b0; seen_valid = 1'b0;
        while (!req_ready_o && cyc < 100) begin
            if (md_op_o != DIVU || md_opa_o != a || md_opb_o != b) md_bad = 1'b1;
            if (res_valid_o) seen_valid = 1'b1;
            flush_i = (cyc == flush_at);
            @(negedge clk);
            cyc++;
        end
        flush_i = 1'b0;
        chk("flush_idle_cycle", cyc, 3 + dext);
        chk("flush_md_held", md_bad, 0);
        chk("flush_no_valid", {seen_valid, res_valid_o}, 2'b00);
    endtask

    task automatic flush_idle();
        flush_i = 1'b1;
        fv = 1'b0;
        @(negedge clk);
        flush_i = 1'b0;
        chk("flush_idle_state", {req_ready_o, res_valid_o}, 2'b10);
    endtask

    iType_e op_tab [0:8] = '{ADD, MUL, MULH, MULHU, MULHSU, DIV, DIVU, REM, REMU};

    initial begin
        logic [31:0] g;
        int          n;
        reset = 1'b1; req_valid_i = 1'b0; req_op_i = NOP; req_rs1_i = '0; req_rs2_i = '0;
        req_rd_i = '0; flush_i = 1'b0; res_ready_i = 1'b0;
        #3;
        chk("rst_ready", req_ready_o, 1);
        chk("rst_valid", res_valid_o, 0);
        chk("rst_md", {md_op_o, md_opa_o, md_opb_o}, '0);
        chk("rst_res", {res_data_o, res_rd_o}, '0);
        @(negedge clk);
        reset = 1'b0;

        // Directed cases.
        do_op(ADD, 32'd5, 32'd6, 5'd1, 0, 0, g);
        chk("nonm_zero", g, 32'h0);
        do_op(MUL, 32'd7, 32'hFFFF_FFFD, 5'd2, 0, 5, g);
        chk("mul_neg", g, 32'hFFFF_FFEB);
        do_op(MULH, 32'h8000_0000, 32'h8000_0000, 5'd3, 0, 0, g);
        chk("mulh_min", g, 32'h4000_0000);
        do_op(MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd4, 0, 1, g);
        chk("mulhu_max", g, 32'hFFFF_FFFE);
        do_op(MULHSU, 32'hFFFF_FFFF, 32'd2, 5'd5, 0, 0, g);
        do_op(DIVU, 32'd100, 32'd7, 5'd6, 6, 0, g);
        chk("divu", g, 32'd14);
        do_op(REMU, 32'd100, 32'd7, 5'd7, 6, 0, g);
        chk("remu_pair", g, 32'd2);
        do_op(DIV, 32'd5, 32'd0, 5'd8, 6, 0, g);
        chk("div_zero", g, 32'hFFFF_FFFF);
        do_op(REM, 32'hFFFF_FFF9, 32'd2, 5'd9, 3, 0, g);
        chk("rem_neg", g, 32'hFFFF_FFFF);
        do_op(DIV, 32'h8000_0000, 32'hFFFF_FFFF, 5'd10, 2, 0, g);
        chk("div_ovf", g, 32'h8000_0000);

        // Cache invalidation by a mul-class op and by an idle flush.
        do_op(DIV, 32'd9, 32'd2, 5'd11, 1, 0, g);
        do_op(MUL, 32'd1, 32'd1, 5'd12, 0, 0, g);
        do_op(REM, 32'd9, 32'd2, 5'd13, 1, 0, g);
        flush_idle();
        do_op(DIV, 32'd9, 32'd2, 5'd14, 1, 0, g);

        // Flushes while busy, then a normal op.
        flush_busy(32'd1000, 32'd7, 4, 2);
        flush_busy(32'd1000, 32'd7, 3, 1);
        do_op(MUL, 32'd3, 32'd4, 5'd15, 0, 0, g);
        chk("mul_after_flush", g, 32'd12);

        // Flush while a result waits for writeback.
        req_valid_i = 1'b1; req_op_i = MUL; req_rs1_i = 32'd2; req_rs2_i = 32'd2; req_rd_i = 5'd16;
        @(negedge clk);
        req_valid_i = 1'b0;
        n = 0;
        while (!res_valid_o && n < 20) begin @(negedge clk); n++; end
        chk("done_before_flush", res_valid_o, 1);
        flush_idle();

        // Flush and request together: request is dropped.
        req_valid_i = 1'b1; req_op_i = MUL; req_rs1_i = 32'd3; flush_i = 1'b1; fv = 1'b0;
        @(negedge clk);
        req_valid_i = 1'b0; flush_i = 1'b0;
        chk("flush_wins_ready", req_ready_o, 1);
        @(negedge clk);
        chk("flush_wins_quiet", {res_valid_o, md_op_o}, '0);

        // Randomised traffic, biased towards partner pairs and corner operands.
        begin
            logic [31:0] la, lb;
            iType_e      lop;
            la = '0; lb = '0; lop = ADD;
            for (int i = 0; i < 40; i++) begin
                iType_e      op;
                logic [31:0] a, b;
                op = op_tab[$urandom_range(0, 8)];
                a = $urandom; b = $urandom;
                case ($urandom_range(0, 7))
                    0:       b = 32'd0;
                    1:       begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                    2:       b = $urandom_range(1, 15);
                    3, 4:    if (is_divc(lop)) begin op = partner(lop); a = la; b = lb; end
                    default: ;
                endcase
                do_op(op, a, b, 5'($urandom), $urandom_range(0, 4), $urandom_range(0, 3), g);
                la = a; lb = b; lop = op;
            end
        end

        // Asynchronous reset in the middle of a divide.
        div_extra = 5;
        req_valid_i = 1'b1; req_op_i = DIV; req_rs1_i = 32'd1000; req_rs2_i = 32'd3; req_rd_i = 5'd20;
        @(negedge clk);
        req_valid_i = 1'b0; req_op_i = NOP;
        @(negedge clk);
        @(negedge clk);
        chk("div_running", md_op_o, DIV);
        #2 reset = 1'b1;
        #1;
        fv = 1'b0;
        chk("arst_ready", req_ready_o, 1);
        chk("arst_valid", res_valid_o, 0);
        chk("arst_md", {md_op_o, md_opa_o, md_opb_o}, '0);
        chk("arst_res", {res_data_o, res_rd_o}, '0);
        @(negedge clk);
        reset = 1'b0;
        do_op(REM, 32'd1000, 32'd3, 5'd21, 2, 0, g);
        chk("rem_after_reset", g, 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
